// File: rtl/logic_op_pipe.sv
// WIDTH-bit AND/XOR/OR/MUX unit over an STAGES-deep valid/ready register pipeline.
// Result on y STAGES-1 edges after acceptance; stalled stages freeze while empty ones still fill.
module logic_op_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [15:0]      out_count
);

    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [15:0]       r_count;

    logic [STAGES-1:0] w_load;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [WIDTH-1:0]  w_res;

    // A stage may load when out_ready is high or any stage at or beyond it is empty;
    // this is the unrolled form of load[i] = !vld[i] || load[i+1].
    always_comb begin
        w_load = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_load[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!r_vld[j]) begin
                    w_load[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (op)
            2'b00:   w_res = a & b;
            2'b01:   w_res = a ^ b;
            2'b10:   w_res = sel ? b : a;
            default: w_res = a | b;
        endcase
    end

    assign in_ready   = !rst && w_load[0];
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_vld[STAGES-1] && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_count <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= w_in_fire;
                if (w_in_fire) begin
                    r_data[0] <= w_res;
                end
            end
            // Data only moves with a valid beat so an emptied output keeps its last value.
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
            if (w_out_fire) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign y         = r_data[STAGES-1];
    assign out_count = r_count;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Randomized scoreboard bench for logic_op_pipe (WIDTH=8, STAGES=2).
module tb_logic_op_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [15:0]      out_count;

    always #5 clk = ~clk;

    logic_op_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_count (out_count)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t             exp_q [$];
    logic [WIDTH-1:0] out_log [$];
    exp_t             e_pop;
    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    bit               chk_lat = 1'b0;
    int               n_in = 0;
    int               n_out = 0;
    logic [15:0]      mdl_cnt = 16'd0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_y = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: the four logic operations straight from their definitions.
    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                                input logic [1:0] rop, input logic rsel);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (rop)
                2'b00:   r[i] = ra[i] && rb[i];
                2'b01:   r[i] = ra[i] != rb[i];
                2'b11:   r[i] = ra[i] || rb[i];
                default: r[i] = rsel ? rb[i] : ra[i];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Input side: every accepted beat pushes its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back('{ref_op(a, b, op, sel), cyc, chk_lat});
            n_in++;
        end
    end

    // Output side: pops and compares on each output transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_cnt    = 16'd0;
            prev_stall = 1'b0;
        end else begin
            check("out_count", 32'(out_count), 32'(mdl_cnt));
            if (prev_stall && out_valid) check("y_stable", 32'(y), 32'(prev_y));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e_pop = exp_q.pop_front();
                    check("y_data", 32'(y), 32'(e_pop.d));
                    if (e_pop.lat) check("latency", 32'(cyc - e_pop.cyc), 32'(STAGES));
                end
                out_log.push_back(y);
                mdl_cnt = mdl_cnt + 16'd1;
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [1:0] vop, input logic vsel);
        bit ok;
        int t;
        in_valid = 1'b1;
        a = va;
        b = vb;
        op = vop;
        sel = vsel;
        t = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            t++;
        end while (!ok && t < 200);
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ops_exp [5];
        logic [15:0]      cnt0;
        int               base_in;
        int               log_base;
        int               base;
        int               guard;

        ops_exp[0] = 8'h4A;
        ops_exp[1] = 8'h95;
        ops_exp[2] = 8'hDF;
        ops_exp[3] = 8'hCA;
        ops_exp[4] = 8'h5F;

        rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = '0; op = 2'b00; sel = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_y", 32'(y), 32'd0);
            check("rst_out_count", 32'(out_count), 32'd0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // All four operations back-to-back with exact latency.
        out_ready = 1'b1;
        chk_lat = 1'b1;
        log_base = out_log.size();
        send(8'hCA, 8'h5F, 2'b00, 1'b0);
        send(8'hCA, 8'h5F, 2'b01, 1'b0);
        send(8'hCA, 8'h5F, 2'b11, 1'b0);
        send(8'hCA, 8'h5F, 2'b10, 1'b0);
        send(8'hCA, 8'h5F, 2'b10, 1'b1);
        drain();
        chk_lat = 1'b0;
        check("ops_count", 32'(out_log.size() - log_base), 32'd5);
        if (out_log.size() - log_base == 5) begin
            for (int i = 0; i < 5; i++) check("ops_value", 32'(out_log[log_base + i]), 32'(ops_exp[i]));
        end

        // Back-pressure: only STAGES beats fit while the output is stalled.
        out_ready = 1'b0;
        base_in = n_in;
        send(8'd1, 8'd0, 2'b11, 1'b0);
        send(8'd2, 8'd0, 2'b11, 1'b0);
        in_valid = 1'b1; a = 8'd3; b = 8'd0; op = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_y_hold", 32'(y), 32'd1);
            tick();
        end
        check("bp_accepted", 32'(n_in - base_in), 32'd2);
        log_base = out_log.size();
        out_ready = 1'b1;
        send(8'd3, 8'd0, 2'b11, 1'b0);
        drain();
        check("bp_out_count", 32'(out_log.size() - log_base), 32'd3);
        if (out_log.size() - log_base == 3) begin
            for (int i = 0; i < 3; i++) check("bp_order", 32'(out_log[log_base + i]), 32'(i + 1));
        end

        // Full pipe with simultaneous input and output transfers.
        out_ready = 1'b0;
        send(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        send(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        cnt0 = out_count;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            op = 2'($urandom_range(0, 3));
            sel = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check("full_count_step", 32'(out_count), 32'(16'(cnt0 + 16'd10)));
        drain();

        // Random traffic on both sides.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            op = 2'($urandom_range(0, 3));
            sel = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(8'hA5, 8'h0F, 2'b01, 1'b0);
        send(8'h3C, 8'hF0, 2'b11, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_count", 32'(out_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_rst_no_output", 32'(out_valid), 32'd0);
        end
        check("mid_rst_count_end", 32'(out_count), 32'd0);

        // Counter wrap over 65537 transfers.
        base = n_out;
        guard = 0;
        out_ready = 1'b1;
        while (n_out - base < 65537 && guard < 70000) begin
            in_valid = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            op = 2'($urandom_range(0, 3));
            sel = 1'($urandom_range(0, 1));
            tick();
            guard++;
            if (n_out - base == 65536) check("wrap_65536", 32'(out_count), 32'h0000);
            if (n_out - base == 65537) check("wrap_65537", 32'(out_count), 32'h0001);
        end
        if (n_out - base < 65537) fail_now("wrap_timeout");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
